// File: rtl/huffman_pkg.sv
// Shared definitions for the Huffman tree builder: FSM state encoding,
// default sizing, and the node-table entry layout used by the table RAM,
// the merge scheduler and the code generator.
package huffman_pkg;

  localparam int SYMS_DEF   = 256;
  localparam int FREQ_W_DEF = 16;
  localparam int NODE_W_DEF = 9;

  typedef enum logic [2:0] {
    IDLE,
    SCAN,
    DRAIN,
    MERGE,
    KILL1,
    KILL2,
    DONE
  } state_e;

  typedef struct packed {
    logic [FREQ_W_DEF-1:0] freq;
    logic [NODE_W_DEF-1:0] left;
    logic [NODE_W_DEF-1:0] right;
    logic                  active;
  } node_t;

endpackage

// File: rtl/huffman_min2_tracker.sv
// Streaming two-minimum finder with active-entry counter.
// Ports:
//   clk, reset   clock, asynchronous active-low reset
//   init         restart the search (min registers to "above any frequency")
//   valid        current entry is present and active
//   freq, idx    current entry
//   min1_*       smallest entry so far, current entry included
//   min2_*       second smallest entry so far, current entry included
//   count        number of valid entries so far, current entry included
// Outputs fold in the entry presented this cycle, so the scheduler can
// decide on the final result in the same cycle the last entry arrives.
module huffman_min2_tracker #(
  parameter int FREQ_W = 16,
  parameter int NODE_W = 9,
  parameter int CNT_W  = NODE_W + 1
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              init,
  input  logic              valid,
  input  logic [FREQ_W-1:0] freq,
  input  logic [NODE_W-1:0] idx,
  output logic [FREQ_W:0]   min1_freq,
  output logic [NODE_W-1:0] min1_idx,
  output logic [FREQ_W:0]   min2_freq,
  output logic [NODE_W-1:0] min2_idx,
  output logic [CNT_W-1:0]  count
);

  logic [FREQ_W:0]   min1_freq_p1, min2_freq_p1;
  logic [NODE_W-1:0] min1_idx_p1, min2_idx_p1;
  logic [CNT_W-1:0]  count_p1;

  // Strict less-than keeps the earlier (lower index) entry on ties.
  always_comb begin
    min1_freq = min1_freq_p1;
    min1_idx  = min1_idx_p1;
    min2_freq = min2_freq_p1;
    min2_idx  = min2_idx_p1;
    count     = count_p1;
    if (valid) begin
      count = count_p1 + CNT_W'(1);
      if ({1'b0, freq} < min1_freq_p1) begin
        min2_freq = min1_freq_p1;
        min2_idx  = min1_idx_p1;
        min1_freq = {1'b0, freq};
        min1_idx  = idx;
      end else if ({1'b0, freq} < min2_freq_p1) begin
        min2_freq = {1'b0, freq};
        min2_idx  = idx;
      end
    end
  end

  // ---- stage p1: running result ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count_p1 <= '0;
    end else if (init) begin
      count_p1 <= '0;
    end else begin
      count_p1 <= count;
    end
  end

  // Initial value sits one above all-ones so an all-ones entry still wins.
  always_ff @(posedge clk) begin
    if (init) begin
      min1_freq_p1 <= {1'b1, {FREQ_W{1'b0}}};
      min2_freq_p1 <= {1'b1, {FREQ_W{1'b0}}};
      min1_idx_p1  <= '0;
      min2_idx_p1  <= '0;
    end else begin
      min1_freq_p1 <= min1_freq;
      min2_freq_p1 <= min2_freq;
      min1_idx_p1  <= min1_idx;
      min2_idx_p1  <= min2_idx;
    end
  end

endmodule

// File: rtl/huffman_merge_sched.sv
// Huffman tree-construction sequencer. Each round scans node table entries
// 0..next_free-1 for the two lowest-frequency active nodes, writes their
// parent at next_free and deactivates both children, until one node is left.
// Ports:
//   clk, reset                 clock, asynchronous active-low reset
//   start, clear               begin build (from IDLE) / synchronous abort
//   mem_raddr/rfreq/ractive    table read port, data one cycle after address
//   mem_we/waddr/wfreq/wleft/wright  parent write port
//   mem_kill/kaddr             deactivate port
//   busy, build_tree_finish    status / one-cycle completion pulse
//   root_idx, empty, sat       result: root, no active leaves, sum saturated
module huffman_merge_sched import huffman_pkg::*; #(
  parameter int SYMS   = SYMS_DEF,
  parameter int FREQ_W = FREQ_W_DEF,
  parameter int NODE_W = NODE_W_DEF
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              start,
  input  logic              clear,
  output logic [NODE_W-1:0] mem_raddr,
  input  logic [FREQ_W-1:0] mem_rfreq,
  input  logic              mem_ractive,
  output logic              mem_we,
  output logic [NODE_W-1:0] mem_waddr,
  output logic [FREQ_W-1:0] mem_wfreq,
  output logic [NODE_W-1:0] mem_wleft,
  output logic [NODE_W-1:0] mem_wright,
  output logic              mem_kill,
  output logic [NODE_W-1:0] mem_kaddr,
  output logic              busy,
  output logic              build_tree_finish,
  output logic [NODE_W-1:0] root_idx,
  output logic              empty,
  output logic              sat
);

  localparam int                CNT_W    = NODE_W + 1;
  localparam logic [NODE_W-1:0] LEAF_END = NODE_W'(SYMS);
  localparam logic [NODE_W-1:0] IDX_MAX  = '1;
  localparam logic [NODE_W-1:0] IDX_ONE  = NODE_W'(1);

  state_e            state;
  logic [NODE_W-1:0] scan_ptr, next_free;
  logic              rd_vld_p0;
  logic [NODE_W-1:0] rd_idx_p0;
  logic              trk_init;
  logic [FREQ_W:0]   min1_freq, min2_freq, pair_sum;
  logic [NODE_W-1:0] min1_idx, min2_idx;
  logic [CNT_W-1:0]  count;

  function automatic logic [FREQ_W-1:0] sat_sum(input logic [FREQ_W:0] s);
    return s[FREQ_W] ? {FREQ_W{1'b1}} : s[FREQ_W-1:0];
  endfunction

  assign mem_raddr = scan_ptr;
  assign busy      = (state != IDLE);
  assign trk_init  = ((state == IDLE) && start) || (state == KILL2);
  // Both operands are real entries when a merge happens, so top bits are 0.
  assign pair_sum  = min1_freq + min2_freq;

  // ---- stage p0: read data returns, tag it with the address issued ----
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      rd_vld_p0 <= 1'b0;
    end else begin
      rd_vld_p0 <= (state == SCAN) && !clear;
    end
  end

  always_ff @(posedge clk) begin
    rd_idx_p0 <= scan_ptr;
  end

  huffman_min2_tracker #(
    .FREQ_W (FREQ_W),
    .NODE_W (NODE_W),
    .CNT_W  (CNT_W)
  ) u_min2 (
    .clk       (clk),
    .reset     (reset),
    .init      (trk_init),
    .valid     (rd_vld_p0 && mem_ractive),
    .freq      (mem_rfreq),
    .idx       (rd_idx_p0),
    .min1_freq (min1_freq),
    .min1_idx  (min1_idx),
    .min2_freq (min2_freq),
    .min2_idx  (min2_idx),
    .count     (count)
  );

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state             <= IDLE;
      scan_ptr          <= '0;
      next_free         <= LEAF_END;
      mem_we            <= 1'b0;
      mem_waddr         <= '0;
      mem_wfreq         <= '0;
      mem_wleft         <= '0;
      mem_wright        <= '0;
      mem_kill          <= 1'b0;
      mem_kaddr         <= '0;
      build_tree_finish <= 1'b0;
      root_idx          <= '0;
      empty             <= 1'b0;
      sat               <= 1'b0;
    end else if (clear) begin
      state             <= IDLE;
      mem_we            <= 1'b0;
      mem_kill          <= 1'b0;
      build_tree_finish <= 1'b0;
    end else begin
      case (state)
        IDLE: begin
          if (start) begin
            state     <= SCAN;
            sat       <= 1'b0;
            empty     <= 1'b0;
            next_free <= LEAF_END;
            scan_ptr  <= '0;
          end
        end
        SCAN: begin
          if (scan_ptr == next_free - IDX_ONE) begin
            state <= DRAIN;
          end else begin
            scan_ptr <= scan_ptr + IDX_ONE;
          end
        end
        DRAIN: begin
          // Tracker outputs already include the last returned entry here.
          if (count == '0) begin
            empty             <= 1'b1;
            root_idx          <= IDX_MAX;
            build_tree_finish <= 1'b1;
            state             <= DONE;
          end else if (count == CNT_W'(1)) begin
            root_idx          <= min1_idx;
            build_tree_finish <= 1'b1;
            state             <= DONE;
          end else if (next_free == IDX_MAX) begin
            sat               <= 1'b1;
            build_tree_finish <= 1'b1;
            state             <= DONE;
          end else begin
            mem_we     <= 1'b1;
            mem_waddr  <= next_free;
            mem_wleft  <= min1_idx;
            mem_wright <= min2_idx;
            mem_wfreq  <= sat_sum(pair_sum);
            if (pair_sum[FREQ_W]) sat <= 1'b1;
            state      <= MERGE;
          end
        end
        MERGE: begin
          mem_we    <= 1'b0;
          mem_kill  <= 1'b1;
          mem_kaddr <= min1_idx;
          state     <= KILL1;
        end
        KILL1: begin
          mem_kaddr <= min2_idx;
          state     <= KILL2;
        end
        KILL2: begin
          mem_kill  <= 1'b0;
          next_free <= next_free + IDX_ONE;
          scan_ptr  <= '0;
          state     <= SCAN;
        end
        DONE: begin
          build_tree_finish <= 1'b0;
          state             <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
